// File: rtl/chirp_pulse_sequencer.sv
// Burst sequencer driving the chirp DDS init/enable strobes and a delayed,
// fixed-length ADC capture window per chirp at a programmable PRF.
module chirp_pulse_sequencer #(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned PERIOD_WIDTH  = 32,
    parameter int unsigned READY_TIMEOUT = 1024,
    parameter int unsigned MIN_PERIOD    = 4
) (
    input  logic                    clk_245,
    input  logic                    clk_245_rst,
    input  logic                    seq_start,
    input  logic                    seq_abort,
    input  logic [CNT_WIDTH-1:0]    cfg_num_chirps,
    input  logic [CNT_WIDTH-1:0]    cfg_adc_delay,
    input  logic [CNT_WIDTH-1:0]    cfg_adc_len,
    input  logic [PERIOD_WIDTH-1:0] cfg_prf_period,
    input  logic                    chirp_ready,
    input  logic                    chirp_done,
    output logic                    chirp_init,
    output logic                    chirp_enable,
    output logic                    adc_enable,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic [CNT_WIDTH-1:0]    chirp_index,
    output logic                    cfg_err,
    output logic                    err_timeout,
    output logic                    err_overrun
);

    localparam int unsigned RUN_WIDTH  = CNT_WIDTH + 2;
    localparam int unsigned WAIT_WIDTH = $clog2(READY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, INIT, WAIT_READY, RUN, GAP, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_WIDTH-1:0]    num_q, delay_q, len_q;
    logic [PERIOD_WIDTH-1:0] period_q, period_cnt;
    logic [WAIT_WIDTH-1:0]   wait_cnt;
    logic [RUN_WIDTH-1:0]    run_cnt, run_nxt, win_end;
    logic                    done_seen;

    logic                    cfg_ok, start_ok, period_hit, period_over, last_chirp, ready_expired;
    logic                    chirp_init_d, chirp_enable_d, adc_enable_d, seq_busy_d, seq_done_d;
    logic                    cfg_err_d, err_timeout_d, err_overrun_d;
    logic [CNT_WIDTH-1:0]    chirp_index_d;

    assign cfg_ok        = (cfg_adc_len != '0) && (cfg_prf_period >= PERIOD_WIDTH'(MIN_PERIOD));
    assign start_ok      = (state == IDLE) && seq_start && cfg_ok;
    assign win_end       = RUN_WIDTH'(delay_q) + RUN_WIDTH'(len_q) - RUN_WIDTH'(1);
    assign period_hit    = period_cnt >= (period_q - PERIOD_WIDTH'(1));
    assign period_over   = period_cnt > (period_q - PERIOD_WIDTH'(1));
    assign last_chirp    = (num_q != '0) && (chirp_index == (num_q - CNT_WIDTH'(1)));
    assign ready_expired = wait_cnt == WAIT_WIDTH'(READY_TIMEOUT - 1);

    // State register
    always_ff @(posedge clk_245) begin
        if (clk_245_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_ok) state_nxt = INIT;
            INIT:       state_nxt = WAIT_READY;
            WAIT_READY: begin
                if (chirp_ready)        state_nxt = RUN;
                else if (ready_expired) state_nxt = IDLE;
            end
            RUN:        if ((done_seen || chirp_done) && (run_cnt >= win_end)) state_nxt = GAP;
            GAP:        if (period_hit) state_nxt = last_chirp ? DONE : INIT;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if ((state != IDLE) && seq_abort) state_nxt = IDLE;
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        run_nxt        = '0;
        chirp_init_d   = (state_nxt == INIT);
        seq_busy_d     = (state_nxt != IDLE);
        seq_done_d     = (state_nxt == DONE);
        cfg_err_d      = (state == IDLE) && seq_start && !cfg_ok;
        chirp_enable_d = (state_nxt == RUN) && ((state != RUN) || (!done_seen && !chirp_done));
        err_timeout_d  = err_timeout;
        err_overrun_d  = err_overrun;
        chirp_index_d  = chirp_index;
        if (state == RUN) run_nxt = (run_cnt != '1) ? run_cnt + RUN_WIDTH'(1) : run_cnt;
        adc_enable_d   = (state_nxt == RUN) && (run_nxt >= RUN_WIDTH'(delay_q)) && (run_nxt <= win_end);
        if (start_ok) begin
            err_timeout_d = 1'b0;
            err_overrun_d = 1'b0;
            chirp_index_d = '0;
        end else if (!seq_abort) begin
            if ((state == WAIT_READY) && !chirp_ready && ready_expired) err_timeout_d = 1'b1;
            if ((state == GAP) && period_over) err_overrun_d = 1'b1;
            if ((state == GAP) && period_hit && !last_chirp) chirp_index_d = chirp_index + CNT_WIDTH'(1);
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk_245) begin
        if (clk_245_rst) begin
            chirp_init   <= 1'b0;
            chirp_enable <= 1'b0;
            adc_enable   <= 1'b0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            cfg_err      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            chirp_index  <= '0;
            num_q        <= '0;
            delay_q      <= '0;
            len_q        <= '0;
            period_q     <= '0;
            period_cnt   <= '0;
            wait_cnt     <= '0;
            run_cnt      <= '0;
            done_seen    <= 1'b0;
        end else begin
            chirp_init   <= chirp_init_d;
            chirp_enable <= chirp_enable_d;
            adc_enable   <= adc_enable_d;
            seq_busy     <= seq_busy_d;
            seq_done     <= seq_done_d;
            cfg_err      <= cfg_err_d;
            err_timeout  <= err_timeout_d;
            err_overrun  <= err_overrun_d;
            chirp_index  <= chirp_index_d;
            run_cnt      <= run_nxt;
            if (start_ok) begin
                num_q    <= cfg_num_chirps;
                delay_q  <= cfg_adc_delay;
                len_q    <= cfg_adc_len;
                period_q <= cfg_prf_period;
            end
            // Period counter is zero in the INIT cycle and saturates rather than wrapping
            if (state_nxt == INIT)     period_cnt <= '0;
            else if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_WIDTH'(1);
            wait_cnt  <= (state == WAIT_READY) ? wait_cnt + WAIT_WIDTH'(1) : '0;
            done_seen <= (state == RUN) && (state_nxt == RUN) && (done_seen || chirp_done);
        end
    end

endmodule

// File: tb/tb_chirp_pulse_sequencer.sv
// Cycle-accurate check of chirp_pulse_sequencer against a timeline model that
// derives every output waveform from per-chirp event times.
`timescale 1ns/1ps
module tb_chirp_pulse_sequencer;

    localparam int MAXC       = 2048;
    localparam int S_CYC      = 2;
    localparam int NORMAL     = 0;
    localparam int DIRECTED   = 1;
    localparam int TIMEOUT    = 2;
    localparam int ABORT_CONT = 3;
    localparam int RAND_ABORT = 4;
    localparam int RESET      = 5;

    logic        clk_245 = 1'b0;
    logic        clk_245_rst = 1'b1;
    logic        seq_start = 1'b0, seq_abort = 1'b0, chirp_ready = 1'b0, chirp_done = 1'b0;
    logic [15:0] cfg_num_chirps = '0, cfg_adc_delay = '0, cfg_adc_len = '0;
    logic [31:0] cfg_prf_period = '0;
    logic        chirp_init, chirp_enable, adc_enable, seq_busy, seq_done;
    logic        cfg_err, err_timeout, err_overrun;
    logic [15:0] chirp_index;

    chirp_pulse_sequencer dut (
        .clk_245        (clk_245),
        .clk_245_rst    (clk_245_rst),
        .seq_start      (seq_start),
        .seq_abort      (seq_abort),
        .cfg_num_chirps (cfg_num_chirps),
        .cfg_adc_delay  (cfg_adc_delay),
        .cfg_adc_len    (cfg_adc_len),
        .cfg_prf_period (cfg_prf_period),
        .chirp_ready    (chirp_ready),
        .chirp_done     (chirp_done),
        .chirp_init     (chirp_init),
        .chirp_enable   (chirp_enable),
        .adc_enable     (adc_enable),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .chirp_index    (chirp_index),
        .cfg_err        (cfg_err),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    always #5 clk_245 = ~clk_245;

    int vec_cnt = 0;
    int miscompares = 0;

    // stimulus and expected waveforms, indexed by cycle within a scenario
    bit st_start [MAXC];
    bit st_abort [MAXC];
    bit st_ready [MAXC];
    bit st_done  [MAXC];
    bit st_rst   [MAXC];
    bit e_init [MAXC];
    bit e_en   [MAXC];
    bit e_adc  [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_cerr [MAXC];
    bit e_to   [MAXC];
    bit e_ov   [MAXC];
    int e_idx  [MAXC];

    int m_idx = 0;
    bit m_to = 1'b0, m_ov = 1'b0;
    int c_num, c_delay, c_len, c_period;

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut=%h model=%h", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Lay out the expected timeline of one start request from chirp event times
    task automatic build(input int num, input int delay, input int len, input int period,
                         input int mode, output int ncyc);
        int I, R, E, w, d, nxt, k, last, a, r, nrec, kk;
        int ast [3];
        int aen [3];
        int rs  [3];
        int re  [3];
        c_num = num; c_delay = delay; c_len = len; c_period = period;
        for (int t = 0; t < MAXC; t++) begin
            st_start[t] = 0; st_abort[t] = 0; st_ready[t] = 0; st_done[t] = 0; st_rst[t] = 0;
            e_init[t] = 0; e_en[t] = 0; e_adc[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_cerr[t] = 0;
            e_idx[t] = m_idx; e_to[t] = m_to; e_ov[t] = m_ov;
        end
        st_start[S_CYC] = 1;
        if (len == 0 || period < 4) begin
            e_cerr[S_CYC+1] = 1;
            ncyc = S_CYC + 6;
            return;
        end
        for (int t = S_CYC + 1; t < MAXC; t++) begin
            e_idx[t] = 0; e_to[t] = 0; e_ov[t] = 0;
        end
        I = S_CYC + 1; k = 0; nrec = 0; last = I;
        forever begin
            e_init[I] = 1;
            if (mode == TIMEOUT) begin
                for (int t = I; t <= I + 1024; t++) e_busy[t] = 1;
                for (int t = I + 1025; t < MAXC; t++) e_to[t] = 1;
                last = I + 1024;
                break;
            end
            w = (mode == DIRECTED) ? 0 : int'($urandom_range(0, 4));
            d = (mode == DIRECTED) ? 5 : int'($urandom_range(0, 14));
            R = I + 2 + w;
            for (int t = I + 1 + w; t <= R + d; t++) st_ready[t] = 1;
            st_done[R+d] = 1;
            for (int t = R; t <= R + d; t++) e_en[t] = 1;
            for (int t = R + delay; t <= R + delay + len - 1; t++) e_adc[t] = 1;
            E = imax(R + d, R + delay + len - 1);
            nxt = imax(E + 2, I + period);
            for (int t = I; t < nxt; t++) e_busy[t] = 1;
            if (k < 3) begin
                ast[k] = R + delay; aen[k] = R + delay + len - 1; rs[k] = R; re[k] = E;
                nrec = k + 1;
            end
            if (E + 2 > I + period)
                for (int t = nxt; t < MAXC; t++) e_ov[t] = 1;
            if (num != 0 && k == num - 1) begin
                e_busy[nxt] = 1; e_done[nxt] = 1; last = nxt;
                break;
            end
            if (num == 0 && k == 2) begin
                last = nxt - 1;
                break;
            end
            for (int t = nxt; t < MAXC; t++) e_idx[t] = k + 1;
            I = nxt; k++;
        end
        a = -1;
        if (mode == ABORT_CONT) begin
            kk = int'($urandom_range(0, nrec - 1));
            a = int'($urandom_range(ast[kk], aen[kk]));
        end else if (mode == RAND_ABORT) begin
            a = int'($urandom_range(S_CYC + 1, last));
        end
        if (a >= 0) begin
            st_abort[a] = 1;
            for (int t = a + 1; t < MAXC; t++) begin
                e_init[t] = 0; e_en[t] = 0; e_adc[t] = 0; e_busy[t] = 0; e_done[t] = 0;
                e_idx[t] = e_idx[a]; e_to[t] = e_to[a]; e_ov[t] = e_ov[a];
            end
            last = a;
        end
        if (mode == RESET) begin
            r = int'($urandom_range(rs[0], re[0]));
            st_rst[r] = 1;
            for (int t = r + 1; t < MAXC; t++) begin
                e_init[t] = 0; e_en[t] = 0; e_adc[t] = 0; e_busy[t] = 0; e_done[t] = 0;
                e_idx[t] = 0; e_to[t] = 0; e_ov[t] = 0;
            end
            last = r;
        end
        // a second start while busy must be ignored
        if ($urandom_range(0, 1) == 1) st_start[$urandom_range(S_CYC + 1, last)] = 1;
        ncyc = last + 8;
    endtask

    task automatic run_scn(input int scn, input int num, input int delay, input int len,
                           input int period, input int mode);
        int ncyc;
        logic [23:0] got, exp;
        build(num, delay, len, period, mode, ncyc);
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk_245);
            #1;
            clk_245_rst = st_rst[t];
            seq_start   = st_start[t];
            seq_abort   = st_abort[t];
            chirp_ready = st_ready[t];
            chirp_done  = st_done[t];
            if (t == S_CYC) begin
                cfg_num_chirps = 16'(c_num);   cfg_adc_delay  = 16'(c_delay);
                cfg_adc_len    = 16'(c_len);   cfg_prf_period = 32'(c_period);
            end else begin
                cfg_num_chirps = 16'($urandom); cfg_adc_delay  = 16'($urandom);
                cfg_adc_len    = 16'($urandom); cfg_prf_period = $urandom;
            end
            @(negedge clk_245);
            got = {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done,
                   cfg_err, err_timeout, err_overrun, chirp_index};
            exp = {e_init[t], e_en[t], e_adc[t], e_busy[t], e_done[t],
                   e_cerr[t], e_to[t], e_ov[t], 16'(e_idx[t])};
            check_eq($sformatf("scn%0d_cyc%0d", scn, t), got, exp);
        end
        m_idx = e_idx[ncyc-1]; m_to = e_to[ncyc-1]; m_ov = e_ov[ncyc-1];
    endtask

    initial begin
        int num, mode, sel;
        repeat (3) @(posedge clk_245);
        @(negedge clk_245);
        check_eq("reset", {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done,
                           cfg_err, err_timeout, err_overrun, chirp_index}, 24'h0);
        run_scn(0, 3, 2, 8, 40, DIRECTED);
        run_scn(1, 2, 1, 0, 20, NORMAL);
        run_scn(2, 2, 1, 4, 3, NORMAL);
        run_scn(3, 2, 1, 4, 20, TIMEOUT);
        run_scn(4, 2, 0, 20, 10, NORMAL);
        run_scn(5, 0, 3, 6, 30, ABORT_CONT);
        run_scn(6, 1, 0, 0, 50, NORMAL);
        run_scn(7, 3, 2, 5, 25, RESET);
        run_scn(8, 2, 0, 1, 4, NORMAL);
        for (int i = 9; i < 40; i++) begin
            num = int'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 9));
            if (num == 0)     mode = (sel < 6) ? ABORT_CONT : RAND_ABORT;
            else if (sel < 6) mode = NORMAL;
            else if (sel < 8) mode = RAND_ABORT;
            else if (sel < 9) mode = ABORT_CONT;
            else              mode = RESET;
            run_scn(i, num, int'($urandom_range(0, 6)), int'($urandom_range(0, 12)),
                    int'($urandom_range(3, 60)), mode);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/chirp_pulse_sequencer.md
Name: chirp_pulse_sequencer

Overview:
Upstream controller for the chirp DDS / ADC capture stage. It generates the chirp_init, chirp_enable and adc_enable strobes that the chirp DDS top consumes. It runs a programmable burst of chirps at a fixed pulse-repetition period. Each chirp gets a delayed, fixed-length ADC capture window, so the downstream FIFO/AXIS path receives one tlast-terminated packet per chirp.

Parameters:
CNT_WIDTH, 16, width of chirp count, ADC delay and ADC length fields
PERIOD_WIDTH, 32, width of PRF period counter
READY_TIMEOUT, 1024, max cycles to wait for chirp_ready after chirp_init
MIN_PERIOD, 4, smallest legal cfg_prf_period

Ports:
clk_245  in  1  245.76 MHz DDS/ADC clock; the only clock
clk_245_rst  in  1  synchronous active-high reset
seq_start  in  1  one-cycle start request
seq_abort  in  1  one-cycle abort request
cfg_num_chirps  in  CNT_WIDTH  chirps per burst; 0 = continuous until abort
cfg_adc_delay  in  CNT_WIDTH  cycles from chirp_enable rise to adc_enable rise
cfg_adc_len  in  CNT_WIDTH  cycles adc_enable is held high per chirp; must be nonzero
cfg_prf_period  in  PERIOD_WIDTH  cycles between successive chirp_init pulses
chirp_ready  in  1  DDS ready for a chirp
chirp_done  in  1  DDS chirp finished (one-cycle pulse)
chirp_init  out  1  one-cycle DDS init pulse
chirp_enable  out  1  DDS chirp run enable
adc_enable  out  1  ADC capture window
seq_busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse when a finite burst completes
chirp_index  out  CNT_WIDTH  index of the current chirp, starting at 0
cfg_err  out  1  one-cycle pulse when a start is rejected
err_timeout  out  1  sticky: chirp_ready wait expired
err_overrun  out  1  sticky: a chirp plus its capture exceeded cfg_prf_period

Behaviour:
- Reset: all outputs and counters are 0; FSM goes to IDLE. Reset mid-burst drops chirp_enable and adc_enable on the next edge.
- All outputs are registered.
- States: IDLE, INIT, WAIT_READY, RUN, GAP, DONE.
- IDLE:
  - seq_start with cfg_adc_len==0 or cfg_prf_period<MIN_PERIOD: pulse cfg_err, stay in IDLE.
  - Otherwise: latch all cfg_* inputs (held for the whole burst), clear both sticky errors, clear chirp_index, go to INIT.
- INIT: chirp_init=1 for exactly one cycle. The period counter loads 0 here and counts every cycle afterwards. Next state is WAIT_READY.
  - Latency: seq_start seen at edge N gives chirp_init high in cycle N+1.
- WAIT_READY:
  - chirp_ready sampled high: go to RUN; chirp_enable rises on the next edge.
  - Wait count reaches READY_TIMEOUT: set err_timeout, go to IDLE. seq_done is not pulsed.
- RUN:
  - chirp_enable is held high until chirp_done is sampled, then cleared on the next edge.
  - The delay counter starts at chirp_enable rise. adc_enable rises exactly cfg_adc_delay cycles later (delay 0 means same cycle as chirp_enable) and stays high exactly cfg_adc_len cycles.
  - The ADC window is independent of chirp_done. It may outlast the chirp.
  - Exit to GAP when chirp_done has been seen and the ADC window is complete.
  - chirp_done and the last ADC cycle may coincide; both are honoured in the same cycle.
- GAP: wait until the period counter equals cfg_prf_period-1. Then:
  - If cfg_num_chirps!=0 and chirp_index==cfg_num_chirps-1: go to DONE.
  - Otherwise: increment chirp_index and go to INIT.
  - Overrun: if the counter already passed cfg_prf_period-1 on GAP entry, set err_overrun and proceed on the next cycle without waiting.
- DONE: seq_done=1 for one cycle, then IDLE.
- Continuous mode (cfg_num_chirps==0): chirp_index wraps modulo 2^CNT_WIDTH.
- seq_abort: highest priority in any non-IDLE state, ahead of simultaneous chirp_done, timeout or seq_start. Next edge clears chirp_enable and adc_enable and returns to IDLE. seq_done and errors are unchanged. Ignored in IDLE.
- seq_start outside IDLE is ignored.

Test Plan:
- num=3, delay=2, len=8, period=40, chirp_ready tied 1, chirp_done 5 cycles after enable -> 3 chirp_init pulses exactly 40 cycles apart; each adc_enable high 8 cycles starting 2 after chirp_enable; chirp_index 0,1,2; seq_done one cycle after the third GAP.
- cfg_adc_len=0, or cfg_prf_period=3 -> cfg_err single pulse, seq_busy stays 0, no chirp_init.
- chirp_ready held 0 -> err_timeout set 1024 cycles after WAIT_READY entry, seq_busy falls, seq_done stays 0.
- period=10, len=20 -> err_overrun set, next chirp_init issued one cycle after capture ends, burst still completes.
- seq_abort asserted during adc_enable in continuous mode -> chirp_enable and adc_enable both 0 on the next edge, FSM in IDLE, no seq_done; a fresh seq_start then clears the errors and restarts at index 0.
- clk_245_rst asserted mid-RUN -> all outputs 0 on the next edge; after release, outputs hold 0 until a new seq_start.
